// File: rtl/exc_pipe_tracker.sv
// Decode-stage legality check plus precise exception tracking through STAGES pipeline registers.
// Define LEGAL_EXT_EN to accept movz/movn/clz/clo/mul as legal encodings.
module exc_pipe_tracker #(
    parameter int STAGES = 2,
    parameter int CODE_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              instr_d,
    input  logic [31:0]              pc_d,
    input  logic                     bd_d,
    input  logic                     adel_d,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [STAGES-1:0]        side_vld,
    input  logic [CODE_W*STAGES-1:0] side_code,
    input  logic                     int_req,
    output logic                     legal_d,
    output logic                     exc_req,
    output logic [CODE_W-1:0]        exc_code,
    output logic [31:0]              exc_epc,
    output logic                     exc_bd
);

    localparam int                LC     = STAGES - 1;
    localparam logic [CODE_W-1:0] C_ADEL = CODE_W'(4);
    localparam logic [CODE_W-1:0] C_RI   = CODE_W'(10);
    localparam logic [CODE_W-1:0] C_INT  = CODE_W'(0);

    function automatic logic f_legal(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       l;
        op = w[31:26];
        rs = w[25:21];
        rt = w[20:16];
        fn = w[5:0];
        l  = 1'b0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                    6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: l = 1'b1;
`ifdef LEGAL_EXT_EN
                    6'h0A, 6'h0B: l = 1'b1;
`else
                    6'h0A, 6'h0B: l = 1'b0;
`endif
                    default: l = 1'b0;
                endcase
            end
            6'h01: l = (rt == 5'd0) || (rt == 5'd1);
            // eret is only legal as the exact word; other CO-space encodings are reserved
            6'h10: l = (rs == 5'd0) || (rs == 5'd4) || (w == 32'h4200_0018);
            6'h1C: begin
`ifdef LEGAL_EXT_EN
                case (fn)
                    6'h20, 6'h21, 6'h02: l = 1'b1;
                    default:             l = 1'b0;
                endcase
`else
                l = 1'b0;
`endif
            end
            6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
            6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21,
            6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: l = 1'b1;
            default: l = 1'b0;
        endcase
        return l;
    endfunction

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_bd;
    logic [STAGES-1:0] r_pend;
    logic [31:0]       r_pc   [STAGES];
    logic [CODE_W-1:0] r_code [STAGES];

    logic [STAGES-1:0] w_nxt_valid;
    logic [STAGES-1:0] w_nxt_bd;
    logic [STAGES-1:0] w_nxt_pend;
    logic [31:0]       w_nxt_pc   [STAGES];
    logic [CODE_W-1:0] w_nxt_code [STAGES];

    logic              w_legal;
    logic              w_d_pend;
    logic [CODE_W-1:0] w_d_code;
    logic              w_clear;
    logic              w_req;
    logic              w_cside;
    logic [CODE_W-1:0] w_cside_code;
    logic [CODE_W-1:0] w_code;
    logic [31:0]       w_epc;
    logic              w_bd;

    assign w_legal      = f_legal(instr_d);
    assign w_d_pend     = adel_d | ~w_legal;
    assign w_d_code     = adel_d ? C_ADEL : C_RI;
    assign w_cside      = side_vld[LC];
    assign w_cside_code = side_code[LC*CODE_W +: CODE_W];
    assign w_req        = r_valid[LC] & (r_pend[LC] | w_cside | int_req);
    assign w_clear      = w_req | flush;

    // Next pipeline contents: clear, bubble or D capture into stage 1, oldest-wins merge downstream.
    always_comb begin
        w_nxt_valid = '0;
        w_nxt_bd    = '0;
        w_nxt_pend  = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_nxt_pc[k]   = 32'd0;
            w_nxt_code[k] = '0;
        end
        if (w_clear) begin
            w_nxt_valid = '0;
        end else begin
            if (stall) begin
                w_nxt_valid[0] = 1'b0;
            end else begin
                w_nxt_valid[0] = 1'b1;
                w_nxt_pc[0]    = pc_d;
                w_nxt_bd[0]    = bd_d;
                w_nxt_pend[0]  = w_d_pend;
                w_nxt_code[0]  = w_d_pend ? w_d_code : '0;
            end
            for (int k = 1; k < STAGES; k++) begin
                w_nxt_valid[k] = r_valid[k-1];
                w_nxt_pc[k]    = r_pc[k-1];
                w_nxt_bd[k]    = r_bd[k-1];
                if (r_pend[k-1]) begin
                    w_nxt_pend[k] = 1'b1;
                    w_nxt_code[k] = r_code[k-1];
                end else if (r_valid[k-1] && side_vld[k-1]) begin
                    w_nxt_pend[k] = 1'b1;
                    w_nxt_code[k] = side_code[(k-1)*CODE_W +: CODE_W];
                end else begin
                    w_nxt_pend[k] = 1'b0;
                    w_nxt_code[k] = '0;
                end
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_bd    <= '0;
            r_pend  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_pc[k]   <= 32'd0;
                r_code[k] <= '0;
            end
        end else begin
            r_valid <= w_nxt_valid;
            r_bd    <= w_nxt_bd;
            r_pend  <= w_nxt_pend;
            for (int k = 0; k < STAGES; k++) begin
                r_pc[k]   <= w_nxt_pc[k];
                r_code[k] <= w_nxt_code[k];
            end
        end
    end

    // Commit-stage exception report; interrupt outranks any recorded exception.
    always_comb begin
        w_code = '0;
        w_epc  = 32'd0;
        w_bd   = 1'b0;
        if (w_req) begin
            if (int_req) begin
                w_code = C_INT;
            end else if (r_pend[LC]) begin
                w_code = r_code[LC];
            end else begin
                w_code = w_cside_code;
            end
            w_epc = r_bd[LC] ? (r_pc[LC] - 32'd4) : r_pc[LC];
            w_bd  = r_bd[LC];
        end else begin
            w_code = '0;
        end
    end

    assign legal_d  = w_legal;
    assign exc_req  = w_req;
    assign exc_code = w_code;
    assign exc_epc  = w_epc;
    assign exc_bd   = w_bd;

endmodule

// File: tb/tb_exc_pipe_tracker.sv
// Self-checking bench for exc_pipe_tracker: directed scenarios plus randomized traffic vs. a queue-level model.
module tb_exc_pipe_tracker;

    localparam int STAGES = 2;
    localparam int CODE_W = 5;
`ifdef LEGAL_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif
    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] BAD  = 32'hFC00_0000;
    localparam logic [31:0] LUI  = 32'h3C01_1234;
    localparam logic [31:0] ADD  = 32'h0022_1820;
    localparam logic [31:0] MUL  = 32'h7062_0002;
    localparam logic [31:0] MOVZ = 32'h0043_200A;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [31:0]              instr_d;
    logic [31:0]              pc_d;
    logic                     bd_d;
    logic                     adel_d;
    logic                     stall;
    logic                     flush;
    logic [STAGES-1:0]        side_vld;
    logic [CODE_W*STAGES-1:0] side_code;
    logic                     int_req;
    logic                     legal_d;
    logic                     exc_req;
    logic [CODE_W-1:0]        exc_code;
    logic [31:0]              exc_epc;
    logic                     exc_bd;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        logic        pend;
        logic [4:0]  code;
    } ent_t;

    ent_t m [STAGES];

    exc_pipe_tracker #(.STAGES(STAGES), .CODE_W(CODE_W)) dut (
        .clk(clk), .reset(reset), .instr_d(instr_d), .pc_d(pc_d), .bd_d(bd_d),
        .adel_d(adel_d), .stall(stall), .flush(flush), .side_vld(side_vld),
        .side_code(side_code), .int_req(int_req), .legal_d(legal_d),
        .exc_req(exc_req), .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd)
    );

    always #5 clk = ~clk;

    function automatic bit ref_legal(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        op = w[31:26];
        fn = w[5:0];
        rs = w[25:21];
        rt = w[20:16];
        if (w == 32'h4200_0018) return 1'b1;
        if (op == 6'h00)
            return (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                               6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h11, 6'h13})
                   || (EXT && (fn inside {6'h0A, 6'h0B}));
        if (op == 6'h01) return (rt == 5'd0) || (rt == 5'd1);
        if (op == 6'h10) return (rs == 5'd0) || (rs == 5'd4);
        if (op == 6'h1C) return EXT && (fn inside {6'h20, 6'h21, 6'h02});
        return op inside {6'h23, 6'h20, 6'h24, 6'h21, 6'h25, 6'h2B, 6'h29, 6'h28,
                          6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0A, 6'h0B,
                          6'h04, 6'h05, 6'h06, 6'h07, 6'h02, 6'h03};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < STAGES; k++) m[k] = '0;
    endtask

    // Advance the model one edge using the inputs currently applied.
    task automatic model_step(input bit take);
        ent_t nm [STAGES];
        bit   bad;
        for (int k = 0; k < STAGES; k++) nm[k] = '0;
        if (!(take || flush)) begin
            bad = adel_d || !ref_legal(instr_d);
            if (!stall) nm[0] = '{1'b1, pc_d, bd_d, bad, adel_d ? 5'd4 : (bad ? 5'd10 : 5'd0)};
            for (int k = 1; k < STAGES; k++) begin
                nm[k] = m[k-1];
                if (m[k-1].valid && !m[k-1].pend && side_vld[k-1]) begin
                    nm[k].pend = 1'b1;
                    nm[k].code = side_code[(k-1)*CODE_W +: CODE_W];
                end
            end
        end
        for (int k = 0; k < STAGES; k++) m[k] = nm[k];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic [31:0] ins, input logic [31:0] pc, input logic bd, input logic adel);
        instr_d = ins;
        pc_d    = pc;
        bd_d    = bd;
        adel_d  = adel;
    endtask

    task automatic quiet();
        drive_d(NOP, 32'h0000_1000, 1'b0, 1'b0);
        stall = 1'b0; flush = 1'b0; side_vld = '0; side_code = '0; int_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        quiet();
        int_req = 1'b1;
        #12;
        if ({exc_req, exc_code, exc_epc, exc_bd} !== 39'd0) begin
            $display("FAIL reset_outputs: got req=%0b code=%0d epc=%0h bd=%0b, want all 0", exc_req, exc_code, exc_epc, exc_bd);
            errors++;
        end
        checks++;
        int_req = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_legal_lui();
        drive_d(LUI, 32'h3000, 1'b0, 1'b0);
        #1;
        if (legal_d !== 1'b1) begin $display("FAIL lui_legal: got %0b want 1", legal_d); errors++; end
        checks++;
        tick();
        drive_d(NOP, 32'h3004, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (exc_req !== 1'b0) begin $display("FAIL lui_no_exc: cycle %0d got %0b want 0", i, exc_req); errors++; end
            checks++;
            tick();
        end
    endtask

    task automatic test_illegal();
        drive_d(BAD, 32'h3004, 1'b0, 1'b0);
        #1;
        if (legal_d !== 1'b0) begin $display("FAIL bad_legal: got %0b want 0", legal_d); errors++; end
        checks++;
        tick();
        drive_d(BAD, 32'h3008, 1'b0, 1'b0);
        tick();
        drive_d(NOP, 32'h300C, 1'b0, 1'b0);
        #1;
        if ({exc_req, exc_code, exc_epc, exc_bd} !== {1'b1, 5'd10, 32'h3004, 1'b0}) begin
            $display("FAIL ri_commit: got req=%0b code=%0d epc=%0h bd=%0b want 1/10/3004/0", exc_req, exc_code, exc_epc, exc_bd);
            errors++;
        end
        checks++;
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            if (exc_req !== 1'b0) begin $display("FAIL ri_cleared: cycle %0d got %0b want 0", i, exc_req); errors++; end
            checks++;
            tick();
        end
    endtask

    task automatic test_older_wins();
        drive_d(BAD, 32'h3008, 1'b1, 1'b0);
        tick();
        drive_d(NOP, 32'h300C, 1'b0, 1'b0);
        side_vld = 2'b01;
        side_code = {5'd0, 5'd12};
        tick();
        side_vld = '0;
        #1;
        if ({exc_req, exc_code, exc_epc, exc_bd} !== {1'b1, 5'd10, 32'h3004, 1'b1}) begin
            $display("FAIL older_wins: got req=%0b code=%0d epc=%0h bd=%0b want 1/10/3004/1", exc_req, exc_code, exc_epc, exc_bd);
            errors++;
        end
        checks++;
        tick();
    endtask

    task automatic test_codes();
        drive_d(BAD, 32'h3010, 1'b0, 1'b1);
        tick();
        drive_d(NOP, 32'h3014, 1'b0, 1'b0);
        tick();
        if ({exc_req, exc_code, exc_epc} !== {1'b1, 5'd4, 32'h3010}) begin
            $display("FAIL adel_code: got req=%0b code=%0d epc=%0h want 1/4/3010", exc_req, exc_code, exc_epc);
            errors++;
        end
        checks++;
        tick();
        drive_d(ADD, 32'h3020, 1'b0, 1'b0);
        tick();
        drive_d(NOP, 32'h3024, 1'b0, 1'b0);
        side_vld = 2'b01; side_code = {5'd0, 5'd12};
        tick();
        side_vld = '0;
        #1;
        if ({exc_req, exc_code, exc_epc} !== {1'b1, 5'd12, 32'h3020}) begin
            $display("FAIL side_code: got req=%0b code=%0d epc=%0h want 1/12/3020", exc_req, exc_code, exc_epc);
            errors++;
        end
        checks++;
        tick();
        drive_d(ADD, 32'h3030, 1'b0, 1'b0);
        tick();
        drive_d(NOP, 32'h3034, 1'b0, 1'b0);
        side_vld = 2'b01; side_code = {5'd0, 5'd12};
        tick();
        side_vld = '0; int_req = 1'b1;
        #1;
        if ({exc_req, exc_code, exc_epc} !== {1'b1, 5'd0, 32'h3030}) begin
            $display("FAIL int_over_pend: got req=%0b code=%0d epc=%0h want 1/0/3030", exc_req, exc_code, exc_epc);
            errors++;
        end
        checks++;
        int_req = 1'b0;
        tick();
    endtask

    task automatic test_stall_int();
        drive_d(NOP, 32'h3040, 1'b0, 1'b0);
        tick();
        stall = 1'b1;
        tick();
        stall = 1'b0;
        drive_d(NOP, 32'h3048, 1'b0, 1'b0);
        #1;
        if (exc_req !== 1'b0) begin $display("FAIL stall_plain: got %0b want 0", exc_req); errors++; end
        checks++;
        tick();
        int_req = 1'b1;
        drive_d(NOP, 32'h304C, 1'b0, 1'b0);
        #1;
        if (exc_req !== 1'b0) begin $display("FAIL bubble_int: got %0b want 0", exc_req); errors++; end
        checks++;
        tick();
        if ({exc_req, exc_code, exc_epc} !== {1'b1, 5'd0, 32'h3048}) begin
            $display("FAIL int_next_valid: got req=%0b code=%0d epc=%0h want 1/0/3048", exc_req, exc_code, exc_epc);
            errors++;
        end
        checks++;
        int_req = 1'b0;
        tick();
        drive_d(NOP, 32'h3050, 1'b0, 1'b0);
        tick();
        tick();
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0; int_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (exc_req !== 1'b0) begin $display("FAIL flush_stall: cycle %0d got %0b want 0", i, exc_req); errors++; end
            checks++;
            tick();
        end
        if (exc_req !== 1'b1) begin $display("FAIL after_flush_int: got %0b want 1", exc_req); errors++; end
        checks++;
        int_req = 1'b0;
        tick();
    endtask

    task automatic test_ext();
        drive_d(MUL, 32'h3060, 1'b0, 1'b0);
        #1;
        if (legal_d !== EXT) begin $display("FAIL mul_legal: got %0b want %0b", legal_d, EXT); errors++; end
        checks++;
        drive_d(MOVZ, 32'h3060, 1'b0, 1'b0);
        #1;
        if (legal_d !== EXT) begin $display("FAIL movz_legal: got %0b want %0b", legal_d, EXT); errors++; end
        checks++;
        drive_d(NOP, 32'h3064, 1'b0, 1'b0);
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        drive_d(BAD, 32'h3070, 1'b0, 1'b0);
        tick();
        drive_d(NOP, 32'h3074, 1'b0, 1'b0);
        tick();
        if (exc_req !== 1'b1) begin $display("FAIL pre_reset_exc: got %0b want 1", exc_req); errors++; end
        checks++;
        reset = 1'b0;
        #1;
        if (exc_req !== 1'b0) begin $display("FAIL reset_async: got %0b want 0", exc_req); errors++; end
        checks++;
        #1 reset = 1'b1;
        tick();
        if (exc_req !== 1'b0) begin $display("FAIL reset_inflight: got %0b want 0", exc_req); errors++; end
        checks++;
    endtask

    task automatic test_random();
        logic [31:0] pool [16] = '{NOP, LUI, ADD, 32'h8C22_0004, 32'hAC22_0004, 32'h1022_0003,
                                   32'h0401_0002, 32'h0402_0002, 32'h4080_6000, 32'h4002_6000,
                                   32'h4200_0018, 32'h4200_0019, MUL, MOVZ, BAD, 32'h7C00_0000};
        ent_t        c;
        bit          e_req;
        logic [4:0]  e_code;
        logic [31:0] e_epc;
        bit          e_bd;
        quiet();
        reset = 1'b0;
        #3;
        model_clear();
        reset = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            drive_d(($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 15)],
                    $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
            stall     = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            int_req   = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < STAGES; k++) side_vld[k] = ($urandom_range(0, 3) == 0);
            side_code = CODE_W*STAGES'($urandom);
            #1;
            c      = m[STAGES-1];
            e_req  = c.valid && (c.pend || side_vld[STAGES-1] || int_req);
            e_code = !e_req ? 5'd0 : int_req ? 5'd0 : c.pend ? c.code : side_code[(STAGES-1)*CODE_W +: CODE_W];
            e_epc  = !e_req ? 32'd0 : c.bd ? c.pc - 32'd4 : c.pc;
            e_bd   = e_req && c.bd;
            if (legal_d !== ref_legal(instr_d)) begin
                $display("FAIL rnd_legal: cyc %0d instr %0h got %0b want %0b", i, instr_d, legal_d, ref_legal(instr_d)); errors++;
            end
            checks++;
            if (exc_req !== e_req) begin $display("FAIL rnd_req: cyc %0d got %0b want %0b", i, exc_req, e_req); errors++; end
            checks++;
            if (exc_code !== e_code) begin $display("FAIL rnd_code: cyc %0d got %0d want %0d", i, exc_code, e_code); errors++; end
            checks++;
            if (exc_epc !== e_epc) begin $display("FAIL rnd_epc: cyc %0d got %0h want %0h", i, exc_epc, e_epc); errors++; end
            checks++;
            if (exc_bd !== e_bd) begin $display("FAIL rnd_bd: cyc %0d got %0b want %0b", i, exc_bd, e_bd); errors++; end
            checks++;
            model_step(e_req);
            tick();
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_legal_lui();
        test_illegal();
        test_older_wins();
        test_codes();
        test_stall_int();
        test_ext();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
